seg_scan_driver: RTL

//  Multiplexed hex 7-segment display driver. It sits directly downstream of the board clock divider.
//  It consumes the divider's slow square wave (scan_clk, ~500 Hz) and scans DIGITS common-anode digits.

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus between the scan driver and its environment: scan step input, display data/masks,
// and the registered display drive outputs.
`timescale 1ns/1ps
interface seg_scan_driver_if #(
   parameter int DIGITS = 8
);
   logic                  scan_clk;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp_mask;
   logic [DIGITS-1:0]     blank_mask;
   logic [DIGITS-1:0]     an;
   logic [6:0]            seg;
   logic                  dp;
   logic                  frame_done;

   modport master (
      output scan_clk, data, dp_mask, blank_mask,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  scan_clk, data, dp_mask, blank_mask,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment scan driver; scan_clk is sampled as data and edge-detected.
// Optional macro SEG_LEAD_ZERO_BLANK_EN darkens digits above the most significant nonzero nibble.
`timescale 1ns/1ps
module seg_scan_driver #(
   parameter int DIGITS     = 8,
   parameter int BLANK_CYC  = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             CLK_in,
   input  logic             rst,
   seg_scan_driver_if.slave bus
);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int CNT_W = $clog2(BLANK_CYC + 1);

   localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic              DP_OFF  = ACTIVE_LOW;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic                s1_reg, s2_reg, s3_reg;
   logic                tick;
   logic                reload;

   logic [4*DIGITS-1:0] shadow_data_reg;
   logic [DIGITS-1:0]   shadow_dp_reg;
   logic [DIGITS-1:0]   shadow_blank_reg;

   logic [DIGITS-1:0]   an_reg, an_next;
   logic [6:0]          seg_reg, seg_next;
   logic                dp_reg, dp_next;
   logic                frame_done_reg, frame_done_next;

   logic [3:0]          nib [DIGITS];
   logic [DIGITS-1:0]   an_onehot;
   logic [DIGITS-1:0]   lead_ok;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0:    hex_decode = 7'h3F;
         4'h1:    hex_decode = 7'h06;
         4'h2:    hex_decode = 7'h5B;
         4'h3:    hex_decode = 7'h4F;
         4'h4:    hex_decode = 7'h66;
         4'h5:    hex_decode = 7'h6D;
         4'h6:    hex_decode = 7'h7D;
         4'h7:    hex_decode = 7'h07;
         4'h8:    hex_decode = 7'h7F;
         4'h9:    hex_decode = 7'h6F;
         4'hA:    hex_decode = 7'h77;
         4'hB:    hex_decode = 7'h7C;
         4'hC:    hex_decode = 7'h39;
         4'hD:    hex_decode = 7'h5E;
         4'hE:    hex_decode = 7'h79;
         default: hex_decode = 7'h71;
      endcase
   endfunction

   // One step per scan_clk rise, two CLK_in edges after the first flop captures it.
   assign tick = s2_reg & ~s3_reg;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]       = shadow_data_reg[4*gi +: 4];
      assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
   end

`ifdef SEG_LEAD_ZERO_BLANK_EN
   // Scan downward from the top digit; digit 0 is always allowed to light.
   always_comb begin
      logic seen;
      seen    = 1'b0;
      lead_ok = '1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         seen       = seen | (|nib[i]);
         lead_ok[i] = seen;
      end
   end
`else
   assign lead_ok = '1;
`endif

   always_ff @(posedge CLK_in or posedge rst) begin
      if (rst) begin
         s1_reg           <= 1'b0;
         s2_reg           <= 1'b0;
         s3_reg           <= 1'b0;
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         idx_reg          <= '0;
         shadow_data_reg  <= '0;
         shadow_dp_reg    <= '0;
         shadow_blank_reg <= '0;
         an_reg           <= AN_OFF;
         seg_reg          <= SEG_OFF;
         dp_reg           <= DP_OFF;
         frame_done_reg   <= 1'b0;
      end else begin
         s1_reg         <= bus.scan_clk;
         s2_reg         <= s1_reg;
         s3_reg         <= s2_reg;
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         idx_reg        <= idx_next;
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         dp_reg         <= dp_next;
         frame_done_reg <= frame_done_next;
         if (reload) begin
            shadow_data_reg  <= bus.data;
            shadow_dp_reg    <= bus.dp_mask;
            shadow_blank_reg <= bus.blank_mask;
         end
      end
   end

   // Output values are derived from the current state and registered, so the display
   // follows a state change by one cycle with an and seg moving together.
   always_comb begin
      logic [DIGITS-1:0] an_act;
      logic [6:0]        seg_act;
      logic              dp_act;

      state_next      = state_reg;
      cnt_next        = cnt_reg;
      idx_next        = idx_reg;
      reload          = 1'b0;
      frame_done_next = 1'b0;
      an_act          = '0;
      seg_act         = '0;
      dp_act          = 1'b0;

      case (state_reg)
         IDLE: begin
            if (tick) begin
               state_next      = BLANK;
               cnt_next        = '0;
               idx_next        = '0;
               reload          = 1'b1;
               frame_done_next = 1'b1;
            end
         end
         BLANK: begin
            // Ticks arriving here are dropped; idx only advances from SHOW.
            if (cnt_reg == CNT_W'(BLANK_CYC - 1)) begin
               state_next = SHOW;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         SHOW: begin
            an_act  = an_onehot & ~shadow_blank_reg & lead_ok;
            seg_act = hex_decode(nib[idx_reg]);
            dp_act  = shadow_dp_reg[idx_reg] & lead_ok[idx_reg];
            if (tick) begin
               state_next = BLANK;
               cnt_next   = '0;
               if (idx_reg == IDX_W'(DIGITS - 1)) begin
                  idx_next        = '0;
                  reload          = 1'b1;
                  frame_done_next = 1'b1;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      an_next  = an_act ^ AN_OFF;
      seg_next = seg_act ^ SEG_OFF;
      dp_next  = dp_act ^ DP_OFF;
   end

   assign bus.an         = an_reg;
   assign bus.seg        = seg_reg;
   assign bus.dp         = dp_reg;
   assign bus.frame_done = frame_done_reg;
endmodule
